// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, parity modes and counter sizing
package uart_pkg;

  // Frame states shared by the transmitter and the receiver
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Parity modes
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Baud ticks per bit produced by the shared baud generator
  localparam int OS_TICK_DEFAULT = 16;

  // Counter width able to hold 0..max_count-1, never narrower than min_width
  function automatic int cnt_width(input int max_count, input int min_width);
    int w;
    w = $clog2(max_count);
    return (w < min_width) ? min_width : w;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART serial transmitter paced by the shared 16x baud tick
module uart_tx
  import uart_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int OS_TICK = OS_TICK_DEFAULT,
  parameter int SB_TICK = 16,
  parameter int PARITY  = PARITY_NONE
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_tx,
  output logic               o_tx_done_tick,
  output logic               o_tx_busy
);

  localparam int TICK_MAX = (OS_TICK > SB_TICK) ? OS_TICK : SB_TICK;
  localparam int TICK_W   = cnt_width(TICK_MAX, 4);
  localparam int BIT_W    = cnt_width(NB_DATA, 1);

  localparam logic [TICK_W-1:0] OS_LAST  = TICK_W'(OS_TICK - 1);
  localparam logic [TICK_W-1:0] SB_LAST  = TICK_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(NB_DATA - 1);

  uart_state_t        state;
  logic [TICK_W-1:0]  tick_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [NB_DATA-1:0] shift_reg;
  logic [NB_DATA-1:0] shift_next;
  logic               parity_bit;

  // Next shift-register value; its LSB is the line level for the following data bit
  assign shift_next = shift_reg >> 1;

  // Frame sequencer; o_tx is loaded with the level of the state being entered
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state          <= ST_IDLE;
      tick_cnt       <= '0;
      bit_cnt        <= '0;
      shift_reg      <= '0;
      parity_bit     <= 1'b0;
      o_tx           <= 1'b1;
      o_tx_done_tick <= 1'b0;
      o_tx_busy      <= 1'b0;
    end else begin
      o_tx_done_tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          o_tx      <= 1'b1;
          o_tx_busy <= 1'b0;
          if (i_tx_start) begin
            shift_reg  <= i_data;
            parity_bit <= (PARITY == PARITY_ODD) ? ~(^i_data) : ^i_data;
            tick_cnt   <= '0;
            state      <= ST_START;
            o_tx       <= 1'b0;
            o_tx_busy  <= 1'b1;
          end
        end

        ST_START: begin
          if (i_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= ST_DATA;
              o_tx     <= shift_reg[0];
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        ST_DATA: begin
          if (i_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt  <= '0;
              shift_reg <= shift_next;
              if (bit_cnt == BIT_LAST) begin
                if (PARITY != PARITY_NONE) begin
                  state <= ST_PARITY;
                  o_tx  <= parity_bit;
                end else begin
                  state <= ST_STOP;
                  o_tx  <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                o_tx    <= shift_next[0];
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        ST_PARITY: begin
          if (i_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              state    <= ST_STOP;
              o_tx     <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        ST_STOP: begin
          if (i_tick) begin
            if (tick_cnt == SB_LAST) begin
              tick_cnt       <= '0;
              state          <= ST_IDLE;
              o_tx           <= 1'b1;
              o_tx_busy      <= 1'b0;
              o_tx_done_tick <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        default: begin
          state     <= ST_IDLE;
          tick_cnt  <= '0;
          bit_cnt   <= '0;
          o_tx      <= 1'b1;
          o_tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;
  import uart_pkg::*;

  typedef logic [191:0] vec_t;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_tick = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic       start2 = 1'b0;
  logic       tx0, tx1, tx2;
  logic       done0, done1, done2;
  logic       busy0, busy1, busy2;

  int n_checks = 0;
  int n_errors = 0;
  int tick_div = 1;
  int done_cnt0 = 0;

  always #5 i_clk = ~i_clk;

  uart_tx #(.NB_DATA(8), .OS_TICK(16), .SB_TICK(16), .PARITY(PARITY_NONE)) u_dut_none (
    .i_clk(i_clk), .i_reset(i_reset), .i_tick(i_tick), .i_tx_start(start0), .i_data(i_data),
    .o_tx(tx0), .o_tx_done_tick(done0), .o_tx_busy(busy0)
  );

  uart_tx #(.NB_DATA(8), .OS_TICK(16), .SB_TICK(16), .PARITY(PARITY_EVEN)) u_dut_even (
    .i_clk(i_clk), .i_reset(i_reset), .i_tick(i_tick), .i_tx_start(start1), .i_data(i_data),
    .o_tx(tx1), .o_tx_done_tick(done1), .o_tx_busy(busy1)
  );

  uart_tx #(.NB_DATA(8), .OS_TICK(16), .SB_TICK(16), .PARITY(PARITY_ODD)) u_dut_odd (
    .i_clk(i_clk), .i_reset(i_reset), .i_tick(i_tick), .i_tx_start(start2), .i_data(i_data),
    .o_tx(tx2), .o_tx_done_tick(done2), .o_tx_busy(busy2)
  );

  task automatic check(input string tag, input vec_t got, input vec_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic tx_of(input int w);
    case (w)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic done_of(input int w);
    case (w)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  // Expected line level per tick (tick every cycle): start, data LSB first, parity, stop
  function automatic vec_t exp_frame(input logic [7:0] d, input int par, input logic par_bit);
    vec_t v;
    int   n;
    v = '0;
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < 16; k++) v[16 + 16*b + k] = d[b];
    n = 144;
    if (par != 0) begin
      for (int k = 0; k < 16; k++) v[144 + k] = par_bit;
      n = 160;
    end
    for (int k = 0; k < 16; k++) v[n + k] = 1'b1;
    return v;
  endfunction

  // Baud tick generator: one pulse every tick_div cycles
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge i_clk);
      #1;
      if (tick_div <= 1) begin
        i_tick = 1'b1;
      end else begin
        i_tick = (ph == 0);
        ph = (ph + 1) % tick_div;
      end
    end
  end

  // Done pulse counter for the no-parity instance
  initial begin
    forever begin
      @(negedge i_clk);
      if (done0 === 1'b1) done_cnt0++;
    end
  end

  task automatic set_start(input int w, input logic v);
    case (w)
      0:       start0 = v;
      1:       start1 = v;
      default: start2 = v;
    endcase
  endtask

  task automatic send(input int w, input logic [7:0] d);
    @(posedge i_clk);
    #1;
    i_data = d;
    set_start(w, 1'b1);
    @(posedge i_clk);
    #1;
    set_start(w, 1'b0);
  endtask

  task automatic capture(input int w, input int n, output vec_t frame, output logic busy_all,
                         output logic done_early);
    frame = '0;
    busy_all = 1'b1;
    done_early = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      frame[i]   = tx_of(w);
      busy_all   = busy_all & busy_of(w);
      done_early = done_early | done_of(w);
    end
  endtask

  // Loopback receiver: samples the line at mid-bit by counting baud ticks
  task automatic rx_frame(input int w, output logic [9:0] bits, output logic timeout);
    int cyc;
    int ticks;
    bits = '0;
    timeout = 1'b0;
    cyc = 0;
    ticks = 0;
    while (tx_of(w) !== 1'b0 && cyc < 2000) begin
      @(negedge i_clk);
      cyc++;
    end
    if (cyc >= 2000) begin
      timeout = 1'b1;
    end else begin
      while (ticks < 160 && cyc < 4000) begin
        if (i_tick) begin
          if (ticks % 16 == 8) bits[ticks/16] = tx_of(w);
          ticks++;
        end
        @(negedge i_clk);
        cyc++;
      end
      if (ticks < 160) timeout = 1'b1;
    end
  endtask

  task automatic wait_idle(input int w, input int limit, output logic timeout);
    int cyc;
    cyc = 0;
    while (busy_of(w) !== 1'b0 && cyc < limit) begin
      @(negedge i_clk);
      cyc++;
    end
    timeout = (cyc >= limit);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       f0, f1, f2;
    logic       b0, b1, b2, d0, d1, d2;
    logic [9:0] rx_bits;
    logic       to;
    int         base;
    logic       line_high;

    // Reset hold with start requested
    i_reset = 1'b0;
    start0 = 1'b1; start1 = 1'b1; start2 = 1'b1;
    i_data = 8'hFF;
    repeat (3) begin
      @(negedge i_clk);
      check("reset_hold_none", vec_t'({tx0, busy0, done0}), vec_t'(3'b100));
      check("reset_hold_par", vec_t'({tx1, busy1, done1, tx2, busy2, done2}), vec_t'(6'b100100));
    end
    @(posedge i_clk);
    #1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    i_reset = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check("idle_after_reset", vec_t'({tx0, busy0, done0}), vec_t'(3'b100));

    // Basic frame 0xA5, no parity, tick every cycle
    tick_div = 1;
    send(0, 8'hA5);
    capture(0, 160, f0, b0, d0);
    check("a5_frame", f0, exp_frame(8'hA5, 0, 1'b0));
    check("a5_busy", vec_t'(b0), vec_t'(1'b1));
    check("a5_no_early_done", vec_t'(d0), vec_t'(1'b0));
    @(negedge i_clk);
    check("a5_done_end", vec_t'({tx0, busy0, done0}), vec_t'(3'b101));

    // Back-to-back: start in the done cycle, one idle-high cycle between frames
    i_data = 8'h81;
    start0 = 1'b1;
    @(posedge i_clk);
    #1;
    start0 = 1'b0;
    capture(0, 160, f0, b0, d0);
    check("b2b_start_bit", vec_t'(f0[0]), vec_t'(1'b0));
    check("b2b_81_frame", f0, exp_frame(8'h81, 0, 1'b0));
    @(negedge i_clk);
    check("b2b_done_end", vec_t'({tx0, busy0, done0}), vec_t'(3'b101));
    @(negedge i_clk);
    check("done_single_cycle", vec_t'(done0), vec_t'(1'b0));

    // Parity: 0x07 has three ones -> even parity bit 1, odd parity bit 0
    repeat (2) @(posedge i_clk);
    #1;
    i_data = 8'h07;
    start1 = 1'b1; start2 = 1'b1;
    @(posedge i_clk);
    #1;
    start1 = 1'b0; start2 = 1'b0;
    fork
      capture(1, 176, f1, b1, d1);
      capture(2, 176, f2, b2, d2);
    join
    check("even_parity_bit", vec_t'(f1[144]), vec_t'(1'b1));
    check("odd_parity_bit", vec_t'(f2[144]), vec_t'(1'b0));
    check("even_frame", f1, exp_frame(8'h07, 1, 1'b1));
    check("odd_frame", f2, exp_frame(8'h07, 2, 1'b0));
    check("parity_busy", vec_t'({b1, b2, d1, d2}), vec_t'(4'b1100));
    @(negedge i_clk);
    check("parity_done_176", vec_t'({done1, busy1, done2, busy2}), vec_t'(4'b1010));

    // Sparse ticks, ignored start mid-DATA, i_data changed after acceptance
    tick_div = 4;
    repeat (8) @(posedge i_clk);
    #1;
    base = done_cnt0;
    fork
      rx_frame(0, rx_bits, to);
      begin
        send(0, 8'h3C);
        repeat (4 * 70) @(posedge i_clk);
        #1;
        i_data = 8'hFF;
        start0 = 1'b1;
        @(posedge i_clk);
        #1;
        start0 = 1'b0;
      end
    join
    check("sparse_rx_timeout", vec_t'(to), vec_t'(1'b0));
    check("sparse_rx_frame", vec_t'(rx_bits), vec_t'(10'h278));
    wait_idle(0, 400, to);
    check("sparse_idle_timeout", vec_t'(to), vec_t'(1'b0));
    repeat (10) @(negedge i_clk);
    check("sparse_one_done", vec_t'(done_cnt0 - base), vec_t'(1));

    // Reset during DATA bit 3 of 0x53 (bit 3 = 0)
    tick_div = 1;
    repeat (4) @(posedge i_clk);
    #1;
    base = done_cnt0;
    send(0, 8'h53);
    repeat (70) @(posedge i_clk);
    @(negedge i_clk);
    check("mid_bit3_level", vec_t'({tx0, busy0}), vec_t'(2'b01));
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    @(negedge i_clk);
    check("mid_reset_line", vec_t'({tx0, busy0, done0}), vec_t'(3'b100));
    line_high = 1'b1;
    repeat (200) begin
      @(negedge i_clk);
      line_high = line_high & tx0 & ~busy0;
    end
    check("mid_reset_idle", vec_t'(line_high), vec_t'(1'b1));
    check("mid_reset_no_done", vec_t'(done_cnt0 - base), vec_t'(0));
    send(0, 8'hC3);
    capture(0, 160, f0, b0, d0);
    check("post_reset_frame", f0, exp_frame(8'hC3, 0, 1'b0));
    @(negedge i_clk);
    check("post_reset_done", vec_t'({tx0, busy0, done0}), vec_t'(3'b101));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART serial transmitter: the transmit-side counterpart of the team's oversampled UART receiver. It accepts a parallel byte on a single-cycle start strobe and serialises it LSB-first as: start bit, NB_DATA data bits, optional parity bit, stop bit(s). Bit timing is paced by the shared baud-rate generator tick (16 ticks per bit). It sits between the interface/ALU control logic and the serial pin, alongside the receiver.

Parameters:
NB_DATA, 8, number of data bits per frame
OS_TICK, 16, baud ticks per start/data/parity bit
SB_TICK, 16, baud ticks for the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2)
PARITY, 0, 0 = none, 1 = even, 2 = odd

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_reset  input  1  synchronous, active-low reset (sampled on i_clk rising edge; 0 = reset)
i_tick  input  1  baud tick from the baud generator, one-cycle pulse, 16x bit rate
i_tx_start  input  1  one-cycle request to send i_data; honoured only in IDLE
i_data  input  NB_DATA  byte to transmit; sampled in the cycle i_tx_start is accepted
o_tx  output  1  serial line, registered; idles high
o_tx_done_tick  output  1  one-cycle pulse at end of stop period
o_tx_busy  output  1  high from the cycle after acceptance until the return to IDLE

Behaviour:
- Reset (i_reset = 0 at a clock edge): state IDLE, o_tx = 1, o_tx_done_tick = 0, o_tx_busy = 0, tick/bit counters = 0, shift register = 0. Overrides any frame in progress; no done pulse; line is high after that edge.
- States: IDLE, START, DATA, PARITY, STOP; encoding 3 bits; unreachable codes -> IDLE with counters cleared.
- IDLE: o_tx = 1. If i_tx_start = 1: latch i_data into the shift register, compute parity (XOR reduction; inverted for odd), clear tick counter, go to START. i_tick is ignored in IDLE.
- START: o_tx = 0. On each i_tick, the tick counter increments; on the tick where count = OS_TICK-1, clear it, clear the bit counter, go to DATA.
- DATA: o_tx = shift_reg[0]. On tick with count = OS_TICK-1: shift right one place, clear count. If bit count = NB_DATA-1, go to PARITY (PARITY != 0) or STOP; otherwise increment the bit count.
- PARITY: o_tx = parity bit, held for OS_TICK ticks, then STOP.
- STOP: o_tx = 1 for SB_TICK ticks. On the tick with count = SB_TICK-1, assert o_tx_done_tick for exactly that cycle and go to IDLE.
- Cycles without i_tick: state and counters hold.
- o_tx is registered from the next-state/next-data logic: the line changes on the clock edge that enters each state. There is no combinational path from any input to o_tx.
- Latency: i_tx_start in cycle t -> o_tx = 0 and o_tx_busy = 1 from edge t+1.
- Frame length in ticks is OS_TICK*(1+NB_DATA+P) + SB_TICK, where P = 1 if PARITY != 0.
- i_tx_start while busy is ignored: no queueing, and in-flight data is not corrupted.
- i_tx_start is accepted in the cycle after o_tx_done_tick (IDLE). Back-to-back frames are separated by exactly one idle-high clock cycle.
- Changes on i_data after acceptance have no effect.
- Tick counter width is $clog2(max(OS_TICK, SB_TICK)), minimum 4 bits. Bit counter width is $clog2(NB_DATA), minimum 1 bit.

Decomposition:
- Shared package uart_pkg: state localparams (IDLE/START/DATA/PARITY/STOP), PARITY encodings (NONE/EVEN/ODD), default OS_TICK = 16. The receiver is also migrated to this package.
- No sub-module: the baud generator is external and shared with the receiver. Parity is an inline reduction XOR.

Test Plan:
- Reset hold: i_reset = 0 for 3 cycles with i_tx_start = 1 -> o_tx = 1, o_tx_busy = 0, o_tx_done_tick = 0 throughout.
- Basic frame: PARITY = 0, i_tick every cycle, send 0xA5 -> o_tx = 0 for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then 1 for 16 cycles. One done pulse at cycle 160 after acceptance; busy high 160 cycles.
- Parity: PARITY = 1 with 0x07 -> parity bit 1; PARITY = 2 with 0x07 -> parity bit 0. Frame is 176 ticks.
- Ignored start and sparse ticks: i_tick every 4th cycle, send 0x3C; pulse i_tx_start with 0xFF mid-DATA -> received byte (via loopback into rx) is 0x3C; exactly one done pulse.
- Back-to-back: i_tx_start the cycle after done with 0x81 -> o_tx high for exactly 1 cycle, then start bit; loopback rx reports 0x81.
- Reset mid-frame: assert i_reset during DATA bit 3 -> o_tx = 1 next edge, no done pulse. The next i_tx_start sends a complete, correct frame.
